// File: rtl/draw_pkg.sv
// Drawing constants and the field bundle carried through the pixel pipeline.
package draw_pkg;

    localparam logic [11:0] WHITE_BALL    = 12'hFFF;
    localparam logic [11:0] BLACK_OUTLINE = 12'h000;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_fields_t;

endpackage

// File: rtl/game_pkg.sv
// Game-level defaults: penalty spot position and ball animation states.
package game_pkg;

    localparam int BALL_START_X = 512;
    localparam int BALL_START_Y = 450;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        HOLD   = 2'd2
    } ball_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour stream passed between drawing stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/ball_motion.sv
// Shot animation: frame-tick detector, IDLE/FLIGHT/HOLD FSM, position
// interpolation and radius shrink. Ball state changes only on a frame tick
// (or on an accepted shot / reset, which never move the ball off the spot).
module ball_motion
    import game_pkg::*;
#(
    parameter int START_X     = BALL_START_X,
    parameter int START_Y     = BALL_START_Y,
    parameter int FLIGHT_LOG2 = 5,
    parameter int HOLD_FRAMES = 16,
    parameter int R_START     = 12,
    parameter int R_END       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        shot_start,
    input  logic [10:0] target_x,
    input  logic [10:0] target_y,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [4:0]  ball_r,
    output logic        shot_busy,
    output logic        shot_done,
    output ball_state_t state_dbg
);

    localparam int FLIGHT_FRAMES = 1 << FLIGHT_LOG2;
    localparam int CNT_MAX       = (FLIGHT_FRAMES > HOLD_FRAMES) ? FLIGHT_FRAMES : HOLD_FRAMES;
    localparam int CW            = $clog2(CNT_MAX + 1);
    localparam logic [10:0] SX   = 11'(START_X);
    localparam logic [10:0] SY   = 11'(START_Y);
    localparam logic [4:0]  RS   = 5'(R_START);
    localparam logic [4:0]  RE   = 5'(R_END);

    ball_state_t state_q, state_d;
    logic          vblnk_q, vblnk_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [10:0]   tx_q, tx_d, ty_q, ty_d;
    logic [10:0]   x_q, x_d, y_q, y_d;
    logic [4:0]    r_q, r_d;
    logic          done_q, done_d;
    logic          tick;
    logic [CW-1:0] k_next;

    // start + ((tgt - start) * k) >>> FLIGHT_LOG2, truncated to 11 bits
    function automatic logic [10:0] lerp(input logic [10:0] start,
                                         input logic [10:0] tgt,
                                         input logic [CW-1:0] k);
        logic signed [12:0]    diff;
        logic signed [13+CW:0] prod;
        logic signed [13+CW:0] shifted;
        diff    = $signed({2'b00, tgt}) - $signed({2'b00, start});
        prod    = diff * $signed({1'b0, k});
        shifted = prod >>> FLIGHT_LOG2;
        return start + shifted[10:0];
    endfunction

    // R_START - ((R_START - R_END) * k >> FLIGHT_LOG2)
    function automatic logic [4:0] radius(input logic [CW-1:0] k);
        logic [15:0] num;
        num = 16'(R_START - R_END) * 16'(k);
        return RS - 5'(num >> FLIGHT_LOG2);
    endfunction

    assign tick = vblnk & ~vblnk_q;

    // State register: all flops, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vblnk_q <= 1'b0;
            cnt_q   <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            x_q     <= SX;
            y_q     <= SY;
            r_q     <= RS;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vblnk_q <= vblnk_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    // Next-state: shot acceptance, per-tick interpolation and hold timing
    always_comb begin
        state_d = state_q;
        vblnk_d = vblnk;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        done_d  = 1'b0;
        k_next  = CW'(cnt_q + 1'b1);
        case (state_q)
            IDLE: begin
                // A tick in this same cycle does not advance: frame shows the spot
                if (shot_start) begin
                    tx_d    = target_x;
                    ty_d    = target_y;
                    cnt_d   = '0;
                    state_d = FLIGHT;
                end
            end
            FLIGHT: begin
                if (tick) begin
                    if (k_next == CW'(FLIGHT_FRAMES)) begin
                        x_d     = tx_q;
                        y_d     = ty_q;
                        r_d     = RE;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        x_d   = lerp(SX, tx_q, k_next);
                        y_d   = lerp(SY, ty_q, k_next);
                        r_d   = radius(k_next);
                        cnt_d = k_next;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (cnt_q == CW'(HOLD_FRAMES - 1)) begin
                        x_d     = SX;
                        y_d     = SY;
                        r_d     = RS;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = k_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ball state, busy flag from state, registered done pulse
    always_comb begin
        ball_x    = x_q;
        ball_y    = y_q;
        ball_r    = r_q;
        shot_busy = (state_q == FLIGHT) || (state_q == HOLD);
        shot_done = done_q;
        state_dbg = state_q;
    end

endmodule

// File: rtl/draw_ball_gk.sv
// Ball overlay: 2-cycle pixel pipeline painting a white disc with a black
// outline ring over the goalkeeper-POV background, plus the shot animator.
module draw_ball_gk
    import draw_pkg::*;
    import game_pkg::*;
#(
    parameter int START_X     = BALL_START_X,
    parameter int START_Y     = BALL_START_Y,
    parameter int FLIGHT_LOG2 = 5,
    parameter int HOLD_FRAMES = 16,
    parameter int R_START     = 12,
    parameter int R_END       = 6,
    parameter int OUTLINE_W   = 2
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           in,
    vga_if.out          out,
    input  logic        shot_start,
    input  logic [10:0] target_x,
    input  logic [10:0] target_y,
    output logic        shot_busy,
    output logic        shot_done,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [4:0]  ball_r,
    output ball_state_t state_dbg
);

    vga_fields_t        s1_q, s1_d, out_q, out_d;
    logic signed [11:0] dx_q, dx_d, dy_q, dy_d;
    logic [4:0]         r1_q, r1_d;
    logic signed [24:0] dx_w, dy_w, d2_s;
    logic [24:0]        d2;
    logic [4:0]         r_in;
    logic [9:0]         r_in_sq, r_sq;

    ball_motion #(
        .START_X    (START_X),
        .START_Y    (START_Y),
        .FLIGHT_LOG2(FLIGHT_LOG2),
        .HOLD_FRAMES(HOLD_FRAMES),
        .R_START    (R_START),
        .R_END      (R_END)
    ) u_motion (
        .clk       (clk),
        .rst       (rst),
        .vblnk     (in.vblnk),
        .shot_start(shot_start),
        .target_x  (target_x),
        .target_y  (target_y),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .ball_r    (ball_r),
        .shot_busy (shot_busy),
        .shot_done (shot_done),
        .state_dbg (state_dbg)
    );

    // Stage 1: offsets from the ball centre, fields and radius captured together
    always_comb begin
        s1_d = '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync,
                 vsync: in.vsync, hblnk: in.hblnk, vblnk: in.vblnk, rgb: in.rgb};
        dx_d = $signed({1'b0, in.hcount}) - $signed({1'b0, ball_x});
        dy_d = $signed({1'b0, in.vcount}) - $signed({1'b0, ball_y});
        r1_d = ball_r;
    end

    // Stage 2: squared distance against inner/outer radius, blanking passes through
    always_comb begin
        dx_w    = 25'(dx_q);
        dy_w    = 25'(dy_q);
        d2_s    = dx_w * dx_w + dy_w * dy_w;
        d2      = d2_s;
        r_in    = r1_q - 5'(OUTLINE_W);
        r_in_sq = 10'(r_in) * 10'(r_in);
        r_sq    = 10'(r1_q) * 10'(r1_q);
        out_d   = s1_q;
        if (s1_q.hblnk || s1_q.vblnk) begin
            out_d.rgb = s1_q.rgb;
        end else if (d2 <= 25'(r_in_sq)) begin
            out_d.rgb = WHITE_BALL;
        end else if (d2 <= 25'(r_sq)) begin
            out_d.rgb = BLACK_OUTLINE;
        end
    end

    // Pipeline registers, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
            r1_q  <= '0;
            out_q <= '0;
        end else begin
            s1_q  <= s1_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            r1_q  <= r1_d;
            out_q <= out_d;
        end
    end

    assign out.hcount = out_q.hcount;
    assign out.vcount = out_q.vcount;
    assign out.hsync  = out_q.hsync;
    assign out.vsync  = out_q.vsync;
    assign out.hblnk  = out_q.hblnk;
    assign out.vblnk  = out_q.vblnk;
    assign out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_ball_gk.sv
// Bench for draw_ball_gk: directed shot scenarios with random targets and
// random pixel bursts, checked against an arithmetic model of the ball.
module tb_draw_ball_gk;
  import draw_pkg::*;
  import game_pkg::*;

  localparam int SX = 512;
  localparam int SY = 450;
  localparam int FRAMES = 32;
  localparam int HOLDN = 16;
  localparam int RS = 12;
  localparam int RE = 6;
  localparam int OW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_if vin();
  vga_if vout();

  logic        shot_start;
  logic [10:0] target_x, target_y;
  logic        shot_busy, shot_done;
  logic [10:0] ball_x, ball_y;
  logic [4:0]  ball_r;
  ball_state_t state_dbg;

  draw_ball_gk dut (
    .clk(clk), .rst(rst), .in(vin), .out(vout),
    .shot_start(shot_start), .target_x(target_x), .target_y(target_y),
    .shot_busy(shot_busy), .shot_done(shot_done),
    .ball_x(ball_x), .ball_y(ball_y), .ball_r(ball_r), .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [37:0] exp_q[$];

  // reference ball
  int m_x, m_y, m_r, m_tx, m_ty;

  always @(negedge clk) if (shot_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // floor((t - s) * k / 2^5) added to s
  function automatic int lerp_m(input int s, input int t, input int k);
    int num, q;
    num = (t - s) * k;
    q = num / FRAMES;
    if (num < 0 && (num % FRAMES) != 0) q = q - 1;
    return (s + q) & 2047;
  endfunction

  function automatic logic [37:0] model_pix(input int h, input int v, input logic hs, input logic vs,
                                            input logic hb, input logic vb, input logic [11:0] rgb);
    int dx, dy, d2, ri;
    logic [11:0] c;
    logic [10:0] h11, v11;
    h11 = 11'(h);
    v11 = 11'(v);
    dx = h - m_x;
    dy = v - m_y;
    d2 = dx * dx + dy * dy;
    ri = m_r - OW;
    if (hb || vb) c = rgb;
    else if (d2 <= ri * ri) c = WHITE_BALL;
    else if (d2 <= m_r * m_r) c = BLACK_OUTLINE;
    else c = rgb;
    return {h11, v11, hs, vs, hb, vb, c};
  endfunction

  function automatic logic [37:0] pack_out();
    return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
  endfunction

  // driver: one pixel per cycle, output checked two cycles later
  task automatic pix_cycle(input int h, input int v, input logic hs, input logic vs,
                           input logic hb, input logic vb, input logic [11:0] rgb);
    @(negedge clk);
    if (exp_q.size() == 2) chk("pixel", 64'(pack_out()), 64'(exp_q.pop_front()));
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync = hs;
    vin.vsync = vs;
    vin.hblnk = hb;
    vin.vblnk = vb;
    vin.rgb = rgb;
    exp_q.push_back(model_pix(h & 2047, v & 2047, hs, vs, hb, vb, rgb));
  endtask

  task automatic pix_flush();
    pix_cycle(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    pix_cycle(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    exp_q.delete();
    vin.vblnk = 1'b0;
  endtask

  task automatic pix_burst(input int n, input bit allow_vb);
    for (int i = 0; i < n; i++) begin
      int h, v;
      h = (m_x + $urandom_range(0, 40) - 20) & 2047;
      v = (m_y + $urandom_range(0, 40) - 20) & 2047;
      pix_cycle(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0),
                allow_vb ? ($urandom_range(0, 7) == 0) : 1'b0,
                12'($urandom_range(0, 4095)));
    end
    pix_flush();
  endtask

  task automatic tick();
    @(negedge clk); vin.vblnk = 1'b1;
    @(negedge clk); vin.vblnk = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_ball(input string tag);
    chk({tag, "_x"}, 64'(ball_x), 64'(m_x));
    chk({tag, "_y"}, 64'(ball_y), 64'(m_y));
    chk({tag, "_r"}, 64'(ball_r), 64'(m_r));
  endtask

  task automatic set_spot();
    m_x = SX; m_y = SY; m_r = RS;
  endtask

  task automatic launch(input int tx, input int ty, input bit with_tick);
    @(negedge clk);
    shot_start = 1'b1; target_x = 11'(tx); target_y = 11'(ty);
    if (with_tick) vin.vblnk = 1'b1;
    @(negedge clk);
    shot_start = 1'b0; vin.vblnk = 1'b0;
    target_x = 11'($urandom_range(0, 2047)); target_y = 11'($urandom_range(0, 2047));
    @(negedge clk);
    m_tx = tx; m_ty = ty;
    chk("launch_busy", 64'(shot_busy), 64'd1);
    chk("launch_state", 64'(state_dbg), 64'(FLIGHT));
    check_ball("launch");
  endtask

  task automatic fly(input bit stray, input int rst_at);
    int px, py, base;
    px = m_x; py = m_y; base = done_cnt;
    for (int k = 1; k <= FRAMES; k++) begin
      tick();
      m_x = lerp_m(SX, m_tx, k);
      m_y = lerp_m(SY, m_ty, k);
      m_r = RS - ((RS - RE) * k) / FRAMES;
      check_ball("flight");
      chk("flight_state", 64'(state_dbg), (k < FRAMES) ? 64'(FLIGHT) : 64'(HOLD));
      chk("mono_x", 64'((m_tx >= SX) ? (int'(ball_x) >= px) : (int'(ball_x) <= px)), 64'd1);
      chk("mono_y", 64'((m_ty >= SY) ? (int'(ball_y) >= py) : (int'(ball_y) <= py)), 64'd1);
      px = ball_x; py = ball_y;
      if (m_tx == 300 && m_ty == 200 && k == 16) begin
        chk("half_x", 64'(ball_x), 64'd406);
        chk("half_y", 64'(ball_y), 64'd325);
        chk("half_r", 64'(ball_r), 64'd9);
      end
      if (stray && k == 5) begin
        @(negedge clk);
        shot_start = 1'b1; target_x = 11'($urandom_range(0, 1023)); target_y = 11'($urandom_range(0, 767));
        @(negedge clk);
        shot_start = 1'b0;
      end
      if (stray && k == 10) pix_burst(60, 1'b0);
      if (k == rst_at) begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        set_spot();
        chk("rst_state", 64'(state_dbg), 64'(IDLE));
        chk("rst_busy", 64'(shot_busy), 64'd0);
        check_ball("rst");
        rst = 1'b0;
        for (int t = 0; t < 20; t++) tick();
        chk("rst_no_done", 64'(done_cnt - base), 64'd0);
        chk("rst_idle", 64'(state_dbg), 64'(IDLE));
        check_ball("rst_after");
        return;
      end
    end
    for (int h = 1; h <= HOLDN; h++) begin
      tick();
      if (h < HOLDN) begin
        chk("hold_busy", 64'(shot_busy), 64'd1);
        chk("hold_nodone", 64'(done_cnt - base), 64'd0);
        check_ball("hold");
      end else begin
        set_spot();
        chk("done_once", 64'(done_cnt - base), 64'd1);
        chk("done_low", 64'(shot_done), 64'd0);
        chk("end_state", 64'(state_dbg), 64'(IDLE));
        chk("end_busy", 64'(shot_busy), 64'd0);
        check_ball("end");
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    shot_start = 1'b0; target_x = '0; target_y = '0;
    vin.hcount = 11'd5; vin.vcount = 11'd7; vin.hsync = 1'b1; vin.vsync = 1'b1;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'h0A0;
    set_spot();
    repeat (3) @(negedge clk);
    chk("reset_out", 64'(pack_out()), 64'd0);
    chk("reset_state", 64'(state_dbg), 64'(IDLE));
    chk("reset_busy", 64'(shot_busy), 64'd0);
    chk("reset_done", 64'(shot_done), 64'd0);
    check_ball("reset");
    rst = 1'b0;

    // directed pixels on a constant background
    pix_cycle(512, 450, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A0);
    pix_cycle(523, 450, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0A0);
    pix_cycle(530, 450, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0A0);
    pix_cycle(512, 440, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A0);
    pix_cycle(512, 450, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0A0);
    pix_flush();
    pix_burst(80, 1'b1);

    // shot to (300,200) with a stray shot_start mid-flight
    launch(300, 200, 1'b0);
    fly(1'b1, 0);

    // positive dx, negative dy
    launch(700, 180, 1'b0);
    fly(1'b0, 0);

    // random targets
    for (int i = 0; i < 2; i++) begin
      launch($urandom_range(0, 1023), $urandom_range(0, 767), 1'b0);
      fly(1'b0, 0);
    end

    // shot accepted on the same cycle as a vblnk rise
    launch(300, 200, 1'b1);
    chk("coinc_x", 64'(ball_x), 64'd512);
    fly(1'b0, 0);

    // reset at tick 10 of a flight
    launch($urandom_range(0, 1023), $urandom_range(0, 767), 1'b0);
    fly(1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
